sipo_deserializer: RTL and testbench



---
 rtl/sipo_deserializer.sv | 150 +++++++++++++++
 tb/tb_sipo_deserializer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//
// Serial-in, parallel-out front end. Accepted serial bits are shifted into an
// internal register; every WIDTH accepted bits form one word, which is handed
// to a one-entry output buffer guarded by a valid/ready handshake. Bit
// collection continues while a word waits in the buffer. A word that
// completes while the buffer is still occupied (and is not being drained
// in that same cycle) is dropped, and the sticky overrun flag is raised.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: first received bit ends up in d_out[WIDTH-1]
//              0: first received bit ends up in d_out[0]
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   sin        serial data bit
//   sin_valid  sin is sampled on this rising edge
//   sync       synchronous restart: discards the partial word
//   d_out      assembled parallel word (registered)
//   d_valid    d_out holds an unconsumed word (registered)
//   d_ready    downstream accepts d_out this cycle
//   overrun    sticky flag: a completed word was dropped (registered)
//   ovr_clr    clears overrun (a new overrun in the same cycle wins)
//   bit_cnt    bits collected in the current partial word (registered)
// -----------------------------------------------------------------------------
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sin,
  input  logic                       sin_valid,
  input  logic                       sync,
  output logic [WIDTH-1:0]           d_out,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic                       overrun,
  input  logic                       ovr_clr,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [WIDTH-1:0] sh_r;
  logic [CW-1:0]    bit_cnt_r;
  logic [WIDTH-1:0] d_out_r;
  logic             d_valid_r;
  logic             overrun_r;

  logic             accept_s;
  logic             complete_s;
  logic             load_s;
  logic             drop_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] sh_s;
  logic [CW-1:0]    bit_cnt_s;
  logic [WIDTH-1:0] d_out_s;
  logic             d_valid_s;
  logic             overrun_s;

  // Shift direction: the assembled word is always the post-shift value.
  always_comb begin
    shifted_s = sh_r;
    if (MSB_FIRST != 0) begin
      shifted_s = {sh_r[WIDTH-2:0], sin};
    end else begin
      shifted_s = {sin, sh_r[WIDTH-1:1]};
    end
  end

  // Accept / complete / buffer-load decisions and next-state values.
  always_comb begin
    accept_s   = sin_valid & ~sync;
    complete_s = accept_s & (bit_cnt_r == CNT_LAST);
    // The buffer can take a new word when empty or when it drains this cycle.
    load_s     = complete_s & (~d_valid_r | d_ready);
    drop_s     = complete_s & ~load_s;

    sh_s      = sh_r;
    bit_cnt_s = bit_cnt_r;
    d_out_s   = d_out_r;
    d_valid_s = d_valid_r;
    overrun_s = overrun_r;

    // sync has priority over a bit arriving in the same cycle.
    if (sync) begin
      sh_s      = {WIDTH{1'b0}};
      bit_cnt_s = CNT_ZERO;
    end else if (accept_s) begin
      sh_s = shifted_s;
      if (complete_s) begin
        bit_cnt_s = CNT_ZERO;
      end else begin
        bit_cnt_s = bit_cnt_r + CNT_ONE;
      end
    end else begin
      sh_s      = sh_r;
      bit_cnt_s = bit_cnt_r;
    end

    // A drain still happens on a sync cycle; d_out keeps its value after drain.
    if (load_s) begin
      d_out_s   = shifted_s;
      d_valid_s = 1'b1;
    end else if (d_valid_r && d_ready) begin
      d_valid_s = 1'b0;
    end else begin
      d_valid_s = d_valid_r;
    end

    // Setting overrun wins over a clear in the same cycle.
    if (drop_s) begin
      overrun_s = 1'b1;
    end else if (ovr_clr) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = overrun_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_r      <= {WIDTH{1'b0}};
      bit_cnt_r <= CNT_ZERO;
      d_out_r   <= {WIDTH{1'b0}};
      d_valid_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      sh_r      <= sh_s;
      bit_cnt_r <= bit_cnt_s;
      d_out_r   <= d_out_s;
      d_valid_r <= d_valid_s;
      overrun_r <= overrun_s;
    end
  end

  assign d_out   = d_out_r;
  assign d_valid = d_valid_r;
  assign overrun = overrun_r;
  assign bit_cnt = bit_cnt_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deserializer
//
// Two instances share the same stimulus: one assembles MSB-first, the other
// LSB-first. A reference model keeps the accepted bits in a queue, builds
// each word arithmetically when WIDTH bits have arrived, and tracks buffer
// occupancy and the overrun flag. Loaded words are pushed into expected
// queues; a monitor pops and compares on every handshake and compares the
// per-cycle outputs against the model.
// -----------------------------------------------------------------------------
module tb_sipo_deserializer;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH);

  logic             clk;
  logic             reset;
  logic             sin;
  logic             sin_valid;
  logic             sync;
  logic             d_ready;
  logic             ovr_clr;
  logic [WIDTH-1:0] d_out_m;
  logic [WIDTH-1:0] d_out_l;
  logic             d_valid_m;
  logic             d_valid_l;
  logic             overrun_m;
  logic             overrun_l;
  logic [CW-1:0]    bit_cnt_m;
  logic [CW-1:0]    bit_cnt_l;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int mbits[$];
  int exp_msb[$];
  int exp_lsb[$];
  int m_occ  = 0;
  int m_ovr  = 0;
  int m_dout_msb = 0;
  int m_dout_lsb = 0;

  sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .d_out(d_out_m), .d_valid(d_valid_m), .d_ready(d_ready),
    .overrun(overrun_m), .ovr_clr(ovr_clr), .bit_cnt(bit_cnt_m)
  );

  sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .d_out(d_out_l), .d_valid(d_valid_l), .d_ready(d_ready),
    .overrun(overrun_l), .ovr_clr(ovr_clr), .bit_cnt(bit_cnt_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: advances on every rising edge, cleared by reset.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mbits.delete();
        exp_msb.delete();
        exp_lsb.delete();
        m_occ = 0;
        m_ovr = 0;
        m_dout_msb = 0;
        m_dout_lsb = 0;
      end else begin
        int  wm;
        int  wl;
        bit  loaded;
        bit  dropped;
        loaded  = 1'b0;
        dropped = 1'b0;
        if (sync) begin
          mbits.delete();
        end else if (sin_valid) begin
          mbits.push_back(int'(sin));
          if (mbits.size() == WIDTH) begin
            wm = 0;
            wl = 0;
            for (int i = 0; i < WIDTH; i++) begin
              wm = wm * 2 + mbits[i];
              wl = wl + (mbits[i] << i);
            end
            mbits.delete();
            if (m_occ == 0 || d_ready) begin
              loaded = 1'b1;
              m_occ = 1;
              m_dout_msb = wm;
              m_dout_lsb = wl;
              exp_msb.push_back(wm);
              exp_lsb.push_back(wl);
            end else begin
              dropped = 1'b1;
            end
          end
        end
        if (!loaded && m_occ == 1 && d_ready) m_occ = 0;
        if (dropped) m_ovr = 1;
        else if (ovr_clr) m_ovr = 0;
      end
    end
  end

  // Monitor: mid-cycle, compare outputs and score handshakes.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("d_valid_msb", int'(d_valid_m), m_occ);
        check("d_valid_lsb", int'(d_valid_l), m_occ);
        check("overrun_msb", int'(overrun_m), m_ovr);
        check("overrun_lsb", int'(overrun_l), m_ovr);
        check("bit_cnt_msb", int'(bit_cnt_m), mbits.size());
        check("bit_cnt_lsb", int'(bit_cnt_l), mbits.size());
        check("d_out_msb", int'(d_out_m), m_dout_msb);
        check("d_out_lsb", int'(d_out_l), m_dout_lsb);
        if (d_valid_m && d_ready) begin
          if (exp_msb.size() == 0) check("sb_msb_empty", 1, 0);
          else check("sb_msb_word", int'(d_out_m), exp_msb.pop_front());
        end
        if (d_valid_l && d_ready) begin
          if (exp_lsb.size() == 0) check("sb_lsb_empty", 1, 0);
          else check("sb_lsb_word", int'(d_out_l), exp_lsb.pop_front());
        end
      end
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic cyc(input logic v, input logic b, input logic sy,
                     input logic rdy, input logic clr);
    sin_valid = v;
    sin       = b;
    sync      = sy;
    d_ready   = rdy;
    ovr_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      cyc(1'b1, w[i], 1'b0, rdy, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout_m"}, int'(d_out_m), 0);
    check({tag, "_dout_l"}, int'(d_out_l), 0);
    check({tag, "_valid"}, int'(d_valid_m | d_valid_l), 0);
    check({tag, "_ovr"}, int'(overrun_m | overrun_l), 0);
    check({tag, "_cnt"}, int'(bit_cnt_m | bit_cnt_l), 0);
  endtask

  initial begin
    int expc[4];
    logic [WIDTH-1:0] w6;
    expc = '{1, 2, 3, 0};
    reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0;
    d_ready = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset");

    // basic word, d_ready high
    for (int i = 0; i < 4; i++) begin
      logic [3:0] pat;
      pat = 4'b1011;
      cyc(1'b1, pat[3-i], 1'b0, 1'b1, 1'b0);
      check("seq_bit_cnt", int'(bit_cnt_m), expc[i]);
    end
    check("basic_msb", int'(d_out_m), 11);
    check("basic_lsb", int'(d_out_l), 13);
    check("basic_valid", int'(d_valid_m), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("basic_valid_drop", int'(d_valid_m), 0);

    // gaps: one bit every third cycle
    for (int i = 0; i < 4; i++) begin
      logic [3:0] pat;
      pat = 4'b1011;
      cyc(1'b1, pat[3-i], 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("gap_msb", int'(d_out_m), 11);

    // back-pressure and overrun
    send_word(4'b1011, 1'b0);
    send_word(4'b0110, 1'b0);
    check("bp_hold", int'(d_out_m), 11);
    check("bp_ovr", int'(overrun_m), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_drain", int'(d_valid_m), 0);
    send_word(4'b0011, 1'b0);
    check("bp_next", int'(d_out_m), 3);
    check("bp_ovr_sticky", int'(overrun_m), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_clr", int'(overrun_m), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // load while draining in the same cycle
    send_word(4'b1011, 1'b0);
    w6 = 4'b0110;
    for (int i = WIDTH - 1; i >= 1; i--) cyc(1'b1, w6[i], 1'b0, 1'b0, 1'b0);
    cyc(1'b1, w6[0], 1'b0, 1'b1, 1'b0);
    check("swap_dout", int'(d_out_m), 6);
    check("swap_valid", int'(d_valid_m), 1);
    check("swap_ovr", int'(overrun_m), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // sync discards partial word
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("sync_cnt", int'(bit_cnt_m), 0);
    send_word(4'b0101, 1'b1);
    check("sync_word", int'(d_out_m), 5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // asynchronous reset mid-word
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_all_zero("areset");
    @(posedge clk);
    #3 reset = 1'b0;
    send_word(4'b1100, 1'b1);
    check("post_reset_msb", int'(d_out_m), 12);
    check("post_reset_lsb", int'(d_out_l), 3);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("final_q_msb", exp_msb.size(), m_occ);
    check("final_q_lsb", exp_lsb.size(), m_occ);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
